// File: rtl/tlut_pkg.sv
// Shared types and default sizing for the temporal-LUT sweep generator.
package tlut_pkg;

  localparam int unsigned N1_DEF        = 4;
  localparam int unsigned N2_DEF        = 4;
  localparam int unsigned IN_WIDTH_DEF  = 4;
  localparam int unsigned ACC_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/tlut_ramp_acc.sv
// One ramp accumulator lane: holds B[i] and presents k*B[i] during a sweep.
module tlut_ramp_acc #(
  parameter int unsigned IN_WIDTH  = 4,
  parameter int unsigned ACC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [IN_WIDTH-1:0]  b_in,
  output logic [ACC_WIDTH-1:0] acc
);

  logic [IN_WIDTH-1:0] b_q;

  // Load clears the ramp and captures the operand; step adds one more B.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q <= '0;
      acc <= '0;
    end else if (load) begin
      b_q <= b_in;
      acc <= '0;
    end else if (step) begin
      acc <= acc + ACC_WIDTH'(b_q);
    end
  end

endmodule

// File: rtl/tlut_sweep_gen.sv
// Temporal-LUT sweep generator: ramps k over the operand range and strobes
// enable[j] when k equals A[j], so the product bank captures k*B[i] = A[j]*B[i].
module tlut_sweep_gen
  import tlut_pkg::*;
#(
  parameter int unsigned N1        = N1_DEF,
  parameter int unsigned N2        = N2_DEF,
  parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [N1-1:0][IN_WIDTH-1:0]       a_in,
  input  logic [N2-1:0][IN_WIDTH-1:0]       b_in,
  output logic                              busy,
  output logic                              valid,
  output logic                              done,
  output logic [N1-1:0]                     enable,
  output logic [N2-1:0][ACC_WIDTH-1:0]      acc_out
);

  localparam logic [IN_WIDTH-1:0] K_LAST = '1;

  // The largest product must fit the ramp without wrapping.
  if (ACC_WIDTH < 2 * IN_WIDTH) begin : g_width_check
    $error("tlut_sweep_gen: ACC_WIDTH must be >= 2*IN_WIDTH");
  end

  state_t                      state;
  state_t                      state_d;
  logic [IN_WIDTH-1:0]         count;
  logic [IN_WIDTH-1:0]         count_d;
  logic [N1-1:0][IN_WIDTH-1:0] a_q;
  logic [N1-1:0][IN_WIDTH-1:0] a_d;
  logic [N1-1:0]               enable_d;
  logic                        lane_load;
  logic                        lane_step;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, next count and next compare mask; the mask is computed one
  // cycle ahead so enable lines up with the registered ramp value.
  always_comb begin
    state_d   = state;
    count_d   = count;
    a_d       = a_q;
    enable_d  = '0;
    lane_load = 1'b0;
    lane_step = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d   = SWEEP;
          count_d   = '0;
          a_d       = a_in;
          lane_load = 1'b1;
          for (int unsigned j = 0; j < N1; j++) begin
            enable_d[j] = (a_in[j] == '0);
          end
        end
      end
      SWEEP: begin
        if (count == K_LAST) begin
          state_d = DONE;
        end else begin
          count_d   = count + IN_WIDTH'(1);
          lane_step = 1'b1;
          for (int unsigned j = 0; j < N1; j++) begin
            enable_d[j] = (a_q[j] == count_d);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sweep counter, latched A operands and registered status/strobe outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      a_q    <= '0;
      enable <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      done   <= 1'b0;
    end else begin
      count  <= count_d;
      a_q    <= a_d;
      enable <= enable_d;
      busy   <= (state_d != IDLE);
      valid  <= (state_d == SWEEP);
      done   <= (state_d == DONE);
    end
  end

  // One ramp lane per B element.
  for (genvar i = 0; i < N2; i++) begin : g_lane
    tlut_ramp_acc #(
      .IN_WIDTH  (IN_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (lane_load),
      .step (lane_step),
      .b_in (b_in[i]),
      .acc  (acc_out[i])
    );
  end

endmodule

// File: tb/tb_tlut_sweep_gen.sv
// Directed and scoreboard bench for tlut_sweep_gen (N1=N2=4, IN_WIDTH=4, ACC_WIDTH=8).
module tb_tlut_sweep_gen;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0][3:0]  a_in;
  logic [3:0][3:0]  b_in;
  logic             busy;
  logic             valid;
  logic             done;
  logic [3:0]       enable;
  logic [3:0][7:0]  acc_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tlut_sweep_gen #(
    .N1(4), .N2(4), .IN_WIDTH(4), .ACC_WIDTH(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .valid   (valid),
    .done    (done),
    .enable  (enable),
    .acc_out (acc_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_en(input logic [3:0][3:0] a, input int k);
    logic [3:0] r;
    for (int j = 0; j < 4; j++) r[j] = (int'(a[j]) == k);
    return r;
  endfunction

  function automatic logic [31:0] exp_acc(input logic [3:0][3:0] b, input int k);
    logic [3:0][7:0] r;
    for (int i = 0; i < 4; i++) r[i] = 8'(int'(b[i]) * k);
    return r;
  endfunction

  // Full sweep with per-step checks; optional directed constants and a
  // mid-sweep start pulse with scrambled operands.
  task automatic sweep_check(input logic [3:0][3:0] a, input logic [3:0][3:0] b,
                             input bit directed, input bit disturb);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (disturb && k == 4) begin
        start = 1'b1;
        a_in  = ~a;
        b_in  = ~b;
      end
      if (disturb && k == 5) start = 1'b0;
      check("sw_valid", 64'(valid), 64'(1));
      check("sw_busy", 64'(busy), 64'(1));
      check("sw_done", 64'(done), 64'(0));
      check("sw_enable", 64'(enable), 64'(exp_en(a, k)));
      check("sw_acc", 64'(acc_out), 64'(exp_acc(b, k)));
      if (directed && k == 0) begin
        check("d_en_k0", 64'(enable), 64'(4'b0010));
        check("d_acc_k0", 64'(acc_out), 64'(0));
      end
      if (directed && k == 3) begin
        check("d_en_k3", 64'(enable), 64'(4'b1001));
        check("d_acc_k3", 64'(acc_out), 64'({8'd45, 8'd3, 8'd15, 8'd6}));
      end
      if (directed && k == 15) begin
        check("d_en_k15", 64'(enable), 64'(4'b0100));
        check("d_acc_k15", 64'(acc_out), 64'({8'd225, 8'd15, 8'd75, 8'd30}));
      end
      tick();
    end
    check("dn_done", 64'(done), 64'(1));
    check("dn_valid", 64'(valid), 64'(0));
    check("dn_enable", 64'(enable), 64'(0));
    check("dn_busy", 64'(busy), 64'(1));
    tick();
    check("end_busy", 64'(busy), 64'(0));
    check("end_done", 64'(done), 64'(0));
    check("end_valid", 64'(valid), 64'(0));
    tick();
    check("idle_busy", 64'(busy), 64'(0));
  endtask

  // Directed operands: a = {3,0,15,3}, b = {2,5,1,15} (element 0 first).
  logic [3:0][3:0] a_dir;
  logic [3:0][3:0] b_dir;

  initial begin
    a_dir = {4'd3, 4'd15, 4'd0, 4'd3};
    b_dir = {4'd15, 4'd1, 4'd5, 4'd2};

    // Reset held with start asserted.
    rst   = 1'b1;
    start = 1'b1;
    a_in  = a_dir;
    b_in  = b_dir;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_enable", 64'(enable), 64'(0));
    check("rst_acc", 64'(acc_out), 64'(0));
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("post_rst_busy", 64'(busy), 64'(0));

    // Directed sweep.
    sweep_check(a_dir, b_dir, 1'b1, 1'b0);

    // Start held high: back-to-back sweeps every 18 cycles.
    begin
      int  rises = 0;
      int  dones = 0;
      int  last_rise = 0;
      int  valid_run = 0;
      logic prev_busy = 1'b0;
      a_in  = a_dir;
      b_in  = b_dir;
      start = 1'b1;
      for (int cyc = 0; cyc < 56; cyc++) begin
        tick();
        if (busy && !prev_busy) begin
          if (rises > 0) check("s3_interval", 64'(cyc - last_rise), 64'(18));
          last_rise = cyc;
          rises++;
        end
        if (valid) valid_run++;
        if (done) begin
          check("s3_valid_cnt", 64'(valid_run), 64'(16));
          valid_run = 0;
          dones++;
        end
        prev_busy = busy;
      end
      check("s3_rises", 64'(rises), 64'(4));
      check("s3_dones", 64'(dones), 64'(3));
      start = 1'b0;
      for (int c = 0; c < 20; c++) tick();
      check("s3_idle", 64'(busy), 64'(0));
    end

    // Start pulse and operand change during a sweep are ignored.
    sweep_check(a_dir, b_dir, 1'b1, 1'b1);

    // Reset at step 7 aborts the sweep.
    a_in  = a_dir;
    b_in  = b_dir;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("s5_en_k7", 64'(enable), 64'(exp_en(a_dir, 7)));
    check("s5_acc_k7", 64'(acc_out), 64'(exp_acc(b_dir, 7)));
    rst = 1'b1;
    tick();
    check("s5_busy", 64'(busy), 64'(0));
    check("s5_valid", 64'(valid), 64'(0));
    check("s5_done", 64'(done), 64'(0));
    check("s5_enable", 64'(enable), 64'(0));
    check("s5_acc", 64'(acc_out), 64'(0));
    rst = 1'b0;
    tick();
    check("s5_no_done", 64'(done), 64'(0));
    check("s5_idle", 64'(busy), 64'(0));
    sweep_check({4'd15, 4'd7, 4'd7, 4'd1}, {4'd9, 4'd0, 4'd15, 4'd4}, 1'b0, 1'b0);

    // Scoreboard over random operand sets.
    for (int s = 0; s < 200; s++) begin
      logic [3:0][3:0] ra;
      logic [3:0][3:0] rb;
      int cnt [4][4];
      for (int i = 0; i < 4; i++) begin
        ra[i] = 4'($urandom_range(15));
        rb[i] = 4'($urandom_range(15));
        for (int j = 0; j < 4; j++) cnt[i][j] = 0;
      end
      a_in  = ra;
      b_in  = rb;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 18; c++) begin
        if (valid) begin
          for (int j = 0; j < 4; j++) begin
            if (enable[j]) begin
              for (int i = 0; i < 4; i++) begin
                check("s6_prod", 64'(acc_out[i]), 64'(int'(ra[j]) * int'(rb[i])));
                cnt[i][j]++;
              end
            end
          end
        end
        tick();
      end
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          check("s6_once", 64'(cnt[i][j]), 64'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
